// File: rtl/hv_link_pkg.sv
// Shared types and frame layout for the HV generator serial link.
package hv_link_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, TAIL, HOLD} state_e;

    localparam int         FRAME_W = 16;
    localparam logic [3:0] HDR     = 4'hA;

    function automatic logic [FRAME_W-1:0] build_frame(input logic [3:0] code,
                                                       input logic [3:0] seq);
        return {HDR, code, ~code, seq};
    endfunction

endpackage

// File: rtl/hv_link_tick.sv
// Free-running 0..DIV-1 divider; tick marks the last count, restart parks it at 0.
module hv_link_tick #(
    parameter int DIV = 50
) (
    input  logic clk,
    input  logic sclr,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || tick) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (sclr) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/hv_link_tx.sv
// Frames the latest HV code (header, code, ~code, seq) and shifts it out over cs_n/sclk/mosi.
module hv_link_tx
    import hv_link_pkg::*;
#(
    parameter int DIV = 50,
    parameter int GAP = 100
) (
    input  logic       clk,
    input  logic       sclr,
    input  logic [3:0] hv_code,
    input  logic       hv_update,
    input  logic       ls,
    output logic       cs_n,
    output logic       sclk,
    output logic       mosi,
    output logic       busy,
    output logic       code_uploaded
);

    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    state_e               state_q, state_d;
    logic [FRAME_W-1:0]   shreg_q, shreg_d;
    logic [4:0]           bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic [3:0]           seq_q, seq_d;
    logic [3:0]           next_code_q, next_code_d;
    logic [3:0]           cur_code_q, cur_code_d;
    logic [3:0]           sent_code_q, sent_code_d;
    logic                 pending_q, pending_d;
    logic                 ls_q, ls_d;
    logic                 cs_n_q, cs_n_d;
    logic                 sclk_q, sclk_d;
    logic                 mosi_q, mosi_d;
    logic                 busy_q, busy_d;
    logic                 upl_q, upl_d;

    logic                 tick;
    logic                 req;
    logic [FRAME_W-1:0]   frame;

    assign req   = hv_update || (ls && !ls_q);
    assign frame = build_frame(next_code_q, seq_q);

    hv_link_tick #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .sclr    (sclr),
        .restart ((state_q == IDLE) || (state_q == HOLD)),
        .tick    (tick)
    );

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        gap_d       = gap_q;
        seq_d       = seq_q;
        next_code_d = next_code_q;
        cur_code_d  = cur_code_q;
        sent_code_d = sent_code_q;
        pending_d   = pending_q;
        ls_d        = ls;
        cs_n_d      = cs_n_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        busy_d      = busy_q;
        upl_d       = upl_q;

        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    shreg_d    = frame;
                    cur_code_d = next_code_q;
                    pending_d  = 1'b0;
                    busy_d     = 1'b1;
                    cs_n_d     = 1'b0;
                    mosi_d     = frame[FRAME_W-1];
                    bit_cnt_d  = '0;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                if (tick) state_d = SHIFT;
            end
            SHIFT: begin
                if (tick) begin
                    if (!sclk_q) begin
                        sclk_d    = 1'b1;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end else begin
                        sclk_d = 1'b0;
                        // After the last fall mosi keeps bit 0 through TAIL and idle.
                        if (bit_cnt_q == 5'(FRAME_W)) begin
                            state_d = TAIL;
                        end else begin
                            mosi_d  = shreg_q[FRAME_W-2];
                            shreg_d = shreg_q << 1;
                        end
                    end
                end
            end
            TAIL: begin
                if (tick) begin
                    cs_n_d      = 1'b1;
                    sent_code_d = cur_code_q;
                    seq_d       = seq_q + 4'd1;
                    gap_d       = '0;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (gap_q == GW'(GAP - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    upl_d   = !pending_q && (sent_code_q == next_code_q);
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A fresh request overrides any pending clear or upload report this cycle.
        if (req) begin
            pending_d   = 1'b1;
            next_code_d = ls ? 4'h0 : hv_code;
            upl_d       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            gap_q       <= '0;
            seq_q       <= '0;
            next_code_q <= '0;
            cur_code_q  <= '0;
            sent_code_q <= '0;
            pending_q   <= 1'b0;
            ls_q        <= 1'b0;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            busy_q      <= 1'b0;
            upl_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_q       <= gap_d;
            seq_q       <= seq_d;
            next_code_q <= next_code_d;
            cur_code_q  <= cur_code_d;
            sent_code_q <= sent_code_d;
            pending_q   <= pending_d;
            ls_q        <= ls_d;
            cs_n_q      <= cs_n_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            busy_q      <= busy_d;
            upl_q       <= upl_d;
        end
    end

    assign cs_n          = cs_n_q;
    assign sclk          = sclk_q;
    assign mosi          = mosi_q;
    assign busy          = busy_q;
    assign code_uploaded = upl_q;

endmodule

// File: tb/tb_hv_link_tx.sv
// Scoreboard bench: stimulus queues expected frames, a link monitor decodes and checks them.
module tb_hv_link_tx;

    logic       clk = 1'b0;
    logic       sclr = 1'b1;
    logic [3:0] hv_code = 4'h0;
    logic       hv_update = 1'b0;
    logic       ls = 1'b0;
    logic       cs_n, sclk, mosi, busy, code_uploaded;

    int nvec = 0;
    int errs = 0;
    logic [15:0] exp_q[$];

    hv_link_tx #(.DIV(2), .GAP(4)) dut (
        .clk           (clk),
        .sclr          (sclr),
        .hv_code       (hv_code),
        .hv_update     (hv_update),
        .ls            (ls),
        .cs_n          (cs_n),
        .sclk          (sclk),
        .mosi          (mosi),
        .busy          (busy),
        .code_uploaded (code_uploaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Link monitor: decode each frame and compare with the head of the queue.
    logic [15:0] bits = '0;
    int          rises = 0, low_cnt = 0;
    logic        saw_rst = 1'b0, cs_prev = 1'b1, sclk_prev = 1'b0;

    always @(negedge clk) begin
        logic [15:0] e;
        if (sclr) saw_rst = 1'b1;
        if (cs_prev && cs_n === 1'b0) begin
            bits = '0; rises = 0; low_cnt = 0; saw_rst = 1'b0;
        end
        if (cs_n === 1'b0) begin
            low_cnt++;
            if (sclk && !sclk_prev) begin
                bits = {bits[14:0], mosi};
                rises++;
            end
        end
        if (!cs_prev && cs_n === 1'b1 && !saw_rst) begin
            if (exp_q.size() == 0) begin
                check("unexpected_frame", int'(bits), -1);
            end else begin
                e = exp_q.pop_front();
                check("frame", int'(bits), int'(e));
                check("sclk_rises", rises, 16);
                check("cs_low_cycles", low_cnt, 68);
                check("sclk_idle_low", int'(sclk), 0);
            end
        end
        cs_prev   = (cs_n === 1'b1);
        sclk_prev = sclk;
    end

    task automatic req(input logic [3:0] c);
        @(negedge clk);
        hv_code   = c;
        hv_update = 1'b1;
        @(negedge clk);
        hv_update = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        sclr = 1'b1;
        repeat (3) @(negedge clk);
        sclr = 1'b0;
    endtask

    task automatic wait_upl(input string name);
        int n = 0;
        while (!code_uploaded && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(code_uploaded), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got stuck, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, k, r;
        logic p;
        logic [3:0] c;

        // Reset then idle
        repeat (3) @(negedge clk);
        sclr = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_cs_n", int'(cs_n), 1);
        check("idle_sclk", int'(sclk), 0);
        check("idle_busy", int'(busy), 0);
        check("idle_upl", int'(code_uploaded), 0);
        repeat (20) @(negedge clk);
        check("idle_cs_n_late", int'(cs_n), 1);
        check("idle_upl_late", int'(code_uploaded), 0);

        // Single frame, with upload timing after cs_n rise
        exp_q.push_back(16'hA5A0);
        req(4'h5);
        @(negedge clk);
        check("start_cs_n", int'(cs_n), 0);
        check("start_busy", int'(busy), 1);
        check("start_mosi_b15", int'(mosi), 1);
        n = 0;
        while (!cs_n && n < 200) begin @(negedge clk); n++; end
        check("single_cs_rise", int'(cs_n), 1);
        check("hold_busy", int'(busy), 1);
        k = 0;
        while (!code_uploaded && k < 20) begin k++; @(negedge clk); end
        check("upl_delay", k, 4);
        check("done_busy", int'(busy), 0);

        // Back-to-back: 7 is overwritten by 9 during the first frame
        do_reset();
        exp_q.push_back(16'hA3C0);
        exp_q.push_back(16'hA961);
        req(4'h3);
        repeat (10) @(negedge clk);
        req(4'h7);
        repeat (5) @(negedge clk);
        req(4'h9);
        wait_upl("b2b_upl");
        check("b2b_drained", exp_q.size(), 0);

        // Limit switch forces code 0 after code 6 is uploaded
        exp_q.push_back(16'hA692);
        req(4'h6);
        wait_upl("code6_upl");
        exp_q.push_back(16'hA0F3);
        ls = 1'b1;
        @(negedge clk);
        check("ls_upl_fall", int'(code_uploaded), 0);
        wait_upl("ls_frame_upl");
        ls = 1'b0;
        repeat (5) @(negedge clk);

        // Mid-frame reset after the 5th sclk rise
        req(4'h2);
        r = 0; n = 0; p = sclk;
        while (r < 5 && n < 200) begin
            @(negedge clk);
            if (sclk && !p) r++;
            p = sclk;
            n++;
        end
        check("abort_rises", r, 5);
        sclr = 1'b1;
        @(negedge clk);
        check("abort_cs_n", int'(cs_n), 1);
        check("abort_sclk", int'(sclk), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_upl", int'(code_uploaded), 0);
        @(negedge clk);
        sclr = 1'b0;
        exp_q.push_back(16'hA4B0);
        req(4'h4);
        wait_upl("post_abort_upl");

        // Sequence number wrap over 17 frames
        do_reset();
        for (int i = 0; i < 17; i++) begin
            c = 4'(i);
            exp_q.push_back({4'hA, c, ~c, c});
            req(c);
            wait_upl("wrap_upl");
        end

        repeat (10) @(negedge clk);
        check("final_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

endmodule
